// File: rtl/issue_fu_scheduler.sv
// issue_fu_scheduler: per-FU ready mask for the issue select logic.
// Tracks occupancy of non-pipelined FUs and reserves CDB writeback slots
// so no more than WB_PORTS results land in one cycle.
// Optional build macro: ISSUE_SCHED_PERF_EN (per-FU stall counters).
module issue_fu_scheduler #(
    parameter int NUM_FU   = 4,
    parameter int MAX_LAT  = 8,
    parameter int WB_PORTS = 2,
    parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_FU*LAT_W-1:0]        cfg_lat_i,
    input  logic [NUM_FU-1:0]              cfg_pipelined_i,
    input  logic [NUM_FU-1:0]              issue_req_i,
    input  logic [NUM_FU-1:0]              issue_v_i,
    input  logic                           flush_i,
    output logic [NUM_FU-1:0]              fu_ready_o,
    output logic [$clog2(WB_PORTS+1)-1:0]  wb_expected_o,
    output logic                           err_o,
    output logic [NUM_FU*32-1:0]           perf_stall_o
);
    localparam int SW = $clog2(WB_PORTS + 1);

    logic [LAT_W-1:0] lat_eff  [NUM_FU];
    logic [LAT_W-1:0] busy_q   [NUM_FU];
    logic [LAT_W-1:0] busy_d   [NUM_FU];
    logic [SW-1:0]    slot_q   [MAX_LAT];
    logic [SW-1:0]    slot_d   [MAX_LAT];
    // slot_q plus a virtual top entry that always reads 0 (latency MAX_LAT)
    logic [SW-1:0]    slot_ext [MAX_LAT+1];
    logic             err_q, err_d;
    logic             multi_hot, bad_issue, accept;

    // Effective latency: clamp configured latency into [1, MAX_LAT]
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            if (cfg_lat_i[f*LAT_W +: LAT_W] == '0)
                lat_eff[f] = LAT_W'(1);
            else if (cfg_lat_i[f*LAT_W +: LAT_W] > LAT_W'(MAX_LAT))
                lat_eff[f] = LAT_W'(MAX_LAT);
            else
                lat_eff[f] = cfg_lat_i[f*LAT_W +: LAT_W];
        end
    end

    // Ready: FU idle and the pre-shift slot its result would land in has room
    always_comb begin
        for (int k = 0; k < MAX_LAT; k++) slot_ext[k] = slot_q[k];
        slot_ext[MAX_LAT] = '0;
        for (int f = 0; f < NUM_FU; f++)
            fu_ready_o[f] = ~reset_i & ~flush_i & (busy_q[f] == '0) &
                            (slot_ext[lat_eff[f]] < SW'(WB_PORTS));
    end

    // Protocol check: multi-hot or issue to a non-ready FU drops the whole vector.
    // During flush ready is forced low, so issues there are ignored, not errors.
    assign multi_hot = |(issue_v_i & (issue_v_i - NUM_FU'(1)));
    assign bad_issue = ~flush_i & (multi_hot | (|(issue_v_i & ~fu_ready_o)));
    assign accept    = ~flush_i & ~bad_issue & (|issue_v_i);

    // Next state: shift reservations down one slot, add accepted issue, age busy counters
    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++) slot_d[k] = slot_q[k+1];
        slot_d[MAX_LAT-1] = '0;
        for (int f = 0; f < NUM_FU; f++)
            busy_d[f] = (busy_q[f] != '0) ? busy_q[f] - LAT_W'(1) : '0;
        if (accept) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (issue_v_i[f]) begin
                    // post-shift index L-1 == pre-shift index L checked by ready
                    for (int k = 0; k < MAX_LAT; k++)
                        if (LAT_W'(k + 1) == lat_eff[f]) slot_d[k] = slot_d[k] + SW'(1);
                    if (!cfg_pipelined_i[f]) busy_d[f] = lat_eff[f] - LAT_W'(1);
                end
            end
        end
        err_d = err_q | bad_issue;
    end

    // Reservation/occupancy state; flush drops everything in flight
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= '0;
            for (int f = 0; f < NUM_FU; f++) busy_q[f] <= '0;
        end else begin
            for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= slot_d[k];
            for (int f = 0; f < NUM_FU; f++) busy_q[f] <= busy_d[f];
        end
    end

    // Sticky error, cleared only by reset (survives flush)
    always_ff @(posedge clk_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o         = err_q & ~reset_i;
    assign wb_expected_o = reset_i ? '0 : slot_q[0];

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] perf_q [NUM_FU];

    // Stall counters: candidate waiting but FU not ready; wrap naturally
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int f = 0; f < NUM_FU; f++) perf_q[f] <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++)
                if (issue_req_i[f] && !fu_ready_o[f]) perf_q[f] <= perf_q[f] + 32'd1;
        end
    end

    // Counters read as zero while reset is asserted
    always_comb begin
        for (int f = 0; f < NUM_FU; f++)
            perf_stall_o[f*32 +: 32] = reset_i ? 32'd0 : perf_q[f];
    end
`else
    logic unused_req;
    assign unused_req   = ^issue_req_i;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_issue_fu_scheduler.sv
// Testbench for issue_fu_scheduler: writeback scoreboard plus per-scenario checks.
module tb_issue_fu_scheduler;
    localparam int NUM_FU = 4, MAX_LAT = 8, WB_PORTS = 2, LAT_W = 4, WBW = 2;
`ifdef ISSUE_SCHED_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd3;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_FU*LAT_W-1:0]  cfg_lat;
    logic [NUM_FU-1:0]        cfg_pipe, req, iv, rdy;
    logic                     flush;
    logic [WBW-1:0]           wbe;
    logic                     err;
    logic [NUM_FU*32-1:0]     perf;

    int passed = 0, total = 0, cyc = 0;
    int sb[$];          // cycle numbers at which a CDB result is due
    bit sb_en = 1'b1;

    issue_fu_scheduler #(.NUM_FU(NUM_FU), .MAX_LAT(MAX_LAT), .WB_PORTS(WB_PORTS), .LAT_W(LAT_W)) dut (
        .clk_i(clk), .reset_i(reset), .cfg_lat_i(cfg_lat), .cfg_pipelined_i(cfg_pipe),
        .issue_req_i(req), .issue_v_i(iv), .flush_i(flush),
        .fu_ready_o(rdy), .wb_expected_o(wbe), .err_o(err), .perf_stall_o(perf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: results due this cycle must match wb_expected_o
    always @(negedge clk) begin
        if (sb_en) begin
            int n;
            n = 0;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i] == cyc) begin n++; sb.delete(i); end
            total++;
            if (wbe !== WBW'(n)) $display("FAIL wb_expected cyc=%0d got %0d want %0d", cyc, wbe, n);
            else passed++;
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; iv = '0; flush = 1'b0; req = '0;
        sb.delete();
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (rdy !== 4'b0000) $display("FAIL reset_ready got %b want 0000", rdy); else passed++;
        total++; if (wbe !== 2'd0) $display("FAIL reset_wb got %0d want 0", wbe); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        total++; if (perf !== '0) $display("FAIL reset_perf got %h want 0", perf); else passed++;
        nxt();
        reset = 1'b0;
        @(negedge clk);
        total++; if (rdy !== 4'b1111) $display("FAIL post_reset_ready got %b want 1111", rdy); else passed++;
        total++; if (err !== 1'b0) $display("FAIL post_reset_err got %b want 0", err); else passed++;
        nxt();
    endtask

    // FU0 pipelined L=3: back-to-back issue, results on consecutive cycles
    task automatic test_pipelined();
        for (int i = 0; i < 3; i++) begin
            iv = 4'b0001; sb.push_back(cyc + 3);
            @(negedge clk);
            total++; if (rdy[0] !== 1'b1) $display("FAIL pipe_ready i=%0d got %b want 1", i, rdy[0]); else passed++;
            nxt();
        end
        iv = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (rdy[0] !== 1'b1) $display("FAIL pipe_ready_idle i=%0d got %b want 1", i, rdy[0]); else passed++;
            total++; if (err !== 1'b0) $display("FAIL pipe_err got %b want 0", err); else passed++;
            nxt();
        end
    endtask

    // FU1 non-pipelined L=4: busy for three cycles after issue
    task automatic test_nonpipe();
        iv = 4'b0010; sb.push_back(cyc + 4);
        @(negedge clk);
        total++; if (rdy[1] !== 1'b1) $display("FAIL np_ready_c0 got %b want 1", rdy[1]); else passed++;
        nxt();
        iv = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            total++;
            if (rdy[1] !== (c == 4)) $display("FAIL np_ready_c%0d got %b want %b", c, rdy[1], c == 4);
            else passed++;
            nxt();
        end
        repeat (2) nxt();
    endtask

    // Two results aimed at one slot saturate it; FU2 (L=1) is blocked until it drains
    task automatic test_wb_conflict();
        iv = 4'b0001; sb.push_back(cyc + 3);          // FU0 L=3
        nxt();
        iv = 4'b1000; sb.push_back(cyc + 2);          // FU3 L=2, same landing cycle
        @(negedge clk);
        total++; if (rdy[3] !== 1'b1) $display("FAIL wbc_ready3 got %b want 1", rdy[3]); else passed++;
        nxt();
        iv = '0;
        @(negedge clk);
        total++; if (rdy !== 4'b1011) $display("FAIL wbc_full got %b want 1011", rdy); else passed++;
        nxt();
        iv = 4'b0100; sb.push_back(cyc + 1);          // FU2 L=1 once slot drains
        @(negedge clk);
        total++; if (rdy[2] !== 1'b1) $display("FAIL wbc_ready2 got %b want 1", rdy[2]); else passed++;
        nxt();
        iv = '0;
        repeat (3) nxt();
        total++; if (err !== 1'b0) $display("FAIL wbc_err got %b want 0", err); else passed++;
    endtask

    // Flush drops FU1 busy and its reservation; issue in flush cycle ignored
    task automatic test_flush();
        iv = 4'b0010;                                  // result is flushed, never expected
        nxt();
        flush = 1'b1; iv = 4'b0001;
        @(negedge clk);
        total++; if (rdy !== 4'b0000) $display("FAIL flush_ready got %b want 0000", rdy); else passed++;
        nxt();
        flush = 1'b0; iv = '0;
        @(negedge clk);
        total++; if (rdy !== 4'b1111) $display("FAIL flush_resume got %b want 1111", rdy); else passed++;
        total++; if (err !== 1'b0) $display("FAIL flush_err got %b want 0", err); else passed++;
        repeat (5) nxt();
    endtask

    // Multi-hot and busy-FU issues set sticky err and leave state untouched
    task automatic test_error();
        iv = 4'b0011;
        @(negedge clk);
        total++; if (err !== 1'b0) $display("FAIL err_early got %b want 0", err); else passed++;
        nxt();
        iv = '0;
        @(negedge clk);
        total++; if (err !== 1'b1) $display("FAIL err_multi got %b want 1", err); else passed++;
        total++; if (rdy !== 4'b1111) $display("FAIL err_ignored got %b want 1111", rdy); else passed++;
        nxt();
        iv = 4'b0010; sb.push_back(cyc + 4);          // legal FU1 issue
        nxt();
        iv = 4'b0010;                                  // FU1 busy: illegal, must not reload
        nxt();
        iv = '0;
        @(negedge clk);
        total++; if (rdy[1] !== 1'b0) $display("FAIL err_busy_ready got %b want 0", rdy[1]); else passed++;
        nxt(); nxt();
        @(negedge clk);
        total++; if (rdy[1] !== 1'b1) $display("FAIL err_no_reload got %b want 1", rdy[1]); else passed++;
        total++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else passed++;
        repeat (3) nxt();
        reset = 1'b1; sb.delete();
        @(negedge clk);
        total++; if (err !== 1'b0) $display("FAIL err_in_reset got %b want 0", err); else passed++;
        nxt();
        reset = 1'b0;
        @(negedge clk);
        total++; if (err !== 1'b0) $display("FAIL err_cleared got %b want 0", err); else passed++;
        nxt();
    endtask

    // Latency clamp: cfg 0 acts as 1, cfg 15 saturates to MAX_LAT
    task automatic test_clamp();
        cfg_lat = {4'd15, 4'd0, 4'd4, 4'd3};
        do_reset();
        iv = 4'b1000; sb.push_back(cyc + MAX_LAT);
        nxt();
        iv = 4'b0100; sb.push_back(cyc + 1);
        nxt();
        iv = 4'b0100; sb.push_back(cyc + 1);
        @(negedge clk);
        total++; if (rdy[2] !== 1'b1) $display("FAIL clamp_l1_reissue got %b want 1", rdy[2]); else passed++;
        nxt();
        iv = '0;
        repeat (8) nxt();
        total++; if (err !== 1'b0) $display("FAIL clamp_err got %b want 0", err); else passed++;
        cfg_lat = {4'd2, 4'd1, 4'd4, 4'd3};
        do_reset();
    endtask

    // Stall counter on FU1 while busy with a waiting candidate
    task automatic test_perf();
        do_reset();
        req = 4'b0010; iv = 4'b0010; sb.push_back(cyc + 4);
        nxt();
        iv = '0;
        repeat (3) nxt();
        req = '0;
        nxt();
        @(negedge clk);
        total++; if (perf[63:32] !== PERF_EXP) $display("FAIL perf_fu1 got %0d want %0d", perf[63:32], PERF_EXP); else passed++;
        total++; if (perf[31:0] !== 32'd0) $display("FAIL perf_fu0 got %0d want 0", perf[31:0]); else passed++;
        nxt();
    endtask

    initial begin
        reset = 1'b1; iv = '0; flush = 1'b0; req = '0;
        cfg_lat  = {4'd2, 4'd1, 4'd4, 4'd3};   // FU3 L2, FU2 L1, FU1 L4, FU0 L3
        cfg_pipe = 4'b1001;                    // FU0, FU3 pipelined
        test_reset();
        test_pipelined();
        test_nonpipe();
        test_wb_conflict();
        test_flush();
        test_error();
        test_clamp();
        test_perf();
        sb_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
